// File: rtl/spi_mmio_master.sv
// SPI mode-0 master behind the MMIO SPI window: TX FIFO of {ignore, byte}, RX FIFO of received bytes.
// Bytes are shifted MSB first; cs_n stays low across back-to-back bytes and for a short trailer after.
module spi_mmio_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_wr,
  input  logic       spi_rd,
  input  logic       spi_addr,
  input  logic [7:0] spi_din,
  input  logic       spi_ignore_response,
  output logic [7:0] spi_dout,
  output logic       spi_buffer_full,
  output logic       spi_buffer_empty,
  output logic       spi_data_avail,
  output logic       spi_busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, TRAIL} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rx_shreg;
  logic          ign;

  logic [8:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]   tx_count;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   rx_count;

  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       tx_nonempty, rx_full;
  logic [8:0] tx_head;

  assign tx_nonempty = (tx_count != '0);
  assign rx_full     = (rx_count == DEPTH);
  assign tx_head     = tx_mem[tx_rd_ptr];

  // FIFO pops/pushes driven by the FSM line up with the state transitions below
  assign tx_push = spi_wr & ~spi_addr & ~spi_buffer_full;
  assign tx_pop  = tx_nonempty & ((state == IDLE) | (state == DONE));
  assign rx_push = (state == DONE) & ~ign & ~rx_full;
  assign rx_pop  = spi_rd & ~spi_addr & spi_data_avail;

  assign spi_buffer_full  = (tx_count == DEPTH);
  assign spi_buffer_empty = ~tx_nonempty;
  assign spi_data_avail   = (rx_count != '0);
  assign spi_busy         = (state != IDLE);
  assign spi_dout         = spi_data_avail ? rx_mem[rx_rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {spi_ignore_response, spi_din};
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      tx_count <= tx_count + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
      rx_count <= rx_count + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      shreg    <= '0;
      rx_shreg <= '0;
      ign      <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_nonempty) begin
            state   <= LOAD;
            cs_n    <= 1'b0;
            ign     <= tx_head[8];
            shreg   <= tx_head[7:0];
            mosi    <= tx_head[7];
            div_cnt <= DIV_M1;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          mosi <= shreg[7];
          if (div_cnt == '0) begin
            state   <= SHIFT;
            div_cnt <= DIV_M1;
          end else begin
            div_cnt <= div_cnt - CW'(1);
          end
        end
        SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_M1;
            sclk    <= ~sclk;
            bit_cnt <= bit_cnt + 4'd1;
            if (!sclk) begin
              rx_shreg <= {rx_shreg[6:0], miso};
            end else begin
              shreg <= {shreg[6:0], 1'b0};
              mosi  <= shreg[6];
            end
            if (bit_cnt == 4'd15) state <= DONE;
          end else begin
            div_cnt <= div_cnt - CW'(1);
          end
        end
        DONE: begin
          // Another byte queued: reload without releasing chip select
          if (tx_nonempty) begin
            state   <= LOAD;
            ign     <= tx_head[8];
            shreg   <= tx_head[7:0];
            mosi    <= tx_head[7];
            div_cnt <= DIV_M1;
            bit_cnt <= '0;
          end else begin
            state   <= TRAIL;
            div_cnt <= DIV_M1;
          end
        end
        TRAIL: begin
          if (div_cnt == '0) begin
            state <= IDLE;
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
          end else begin
            div_cnt <= div_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mmio_master.sv
// Randomized self-checking bench for spi_mmio_master against a byte-level transfer model.
module tb_spi_mmio_master;
  localparam int CD    = 4;
  localparam int DEPTH = 8;
  localparam int BYTE_CYC = 17 * CD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_wr = 1'b0, spi_rd = 1'b0, spi_addr = 1'b0;
  logic [7:0] spi_din = '0;
  logic       spi_ignore_response = 1'b0;
  logic [7:0] spi_dout;
  logic       spi_buffer_full, spi_buffer_empty, spi_data_avail, spi_busy;
  logic       sclk, mosi, miso, cs_n;

  logic miso_mode = 1'b0;
  logic miso_inv  = 1'b0;
  assign miso = miso_mode ? 1'b1 : (mosi ^ miso_inv);

  spi_mmio_master #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr),
    .spi_din(spi_din), .spi_ignore_response(spi_ignore_response), .spi_dout(spi_dout),
    .spi_buffer_full(spi_buffer_full), .spi_buffer_empty(spi_buffer_empty),
    .spi_data_avail(spi_data_avail), .spi_busy(spi_busy), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus monitor: bytes seen on mosi at sclk rising edges, chip-select low length
  logic [7:0] obs_tx[$];
  logic [7:0] mon_acc = '0;
  int mon_nb = 0, low_cnt = 0, last_low = 0, rise_total = 0, full_cycles = 0;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_nb  = 0;
      low_cnt = 0;
    end else begin
      if (cs_n) begin
        if (low_cnt != 0) last_low = low_cnt;
        low_cnt = 0;
        mon_nb  = 0;
      end else begin
        low_cnt++;
      end
      if (!cs_n && sclk && !prev_sclk) begin
        rise_total++;
        mon_acc = {mon_acc[6:0], mosi};
        mon_nb++;
        if (mon_nb == 8) begin
          obs_tx.push_back(mon_acc);
          mon_nb = 0;
        end
      end
      if (spi_buffer_full) full_cycles++;
    end
    prev_sclk = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wr_data [16];
  logic       wr_ign  [16];

  task automatic write_burst(input int n);
    for (int i = 0; i < n; i++) begin
      spi_wr = 1'b1; spi_addr = 1'b0;
      spi_din = wr_data[i]; spi_ignore_response = wr_ign[i];
      tick();
    end
    spi_wr = 1'b0; spi_ignore_response = 1'b0;
  endtask

  task automatic read_port(input logic addr, output logic [7:0] val);
    spi_rd = 1'b1; spi_addr = addr;
    val = spi_dout;
    tick();
    spi_rd = 1'b0; spi_addr = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    repeat (2) tick();
    while ((spi_busy || !spi_buffer_empty) && c < bound) begin
      tick();
      c++;
    end
    check("idle_timeout", {31'd0, c < bound}, 32'd1);
    tick();
  endtask

  // Model: consecutive writes from idle are accepted up to DEPTH+1 (one already popped),
  // the RX FIFO keeps the first DEPTH non-ignored responses.
  task automatic run_burst(input int n, input bit lat_check, input bit drain);
    int base_tx = obs_tx.size();
    int base_rise = rise_total;
    int base_full = full_cycles;
    int acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
    logic [7:0] exp_rx[$];
    logic [7:0] v;
    write_burst(n);
    if (lat_check) begin
      check("cs_before_latency", {31'd0, cs_n}, 32'd1);
      tick();
      check("cs_after_latency", {31'd0, cs_n}, 32'd0);
    end
    wait_idle(40 * BYTE_CYC);
    check("tx_bytes", obs_tx.size() - base_tx, acc);
    for (int i = 0; i < acc; i++)
      if (base_tx + i < obs_tx.size()) check("tx_data", {24'd0, obs_tx[base_tx + i]}, {24'd0, wr_data[i]});
    check("sclk_pulses", rise_total - base_rise, 8 * acc);
    check("cs_low_len", last_low, acc * BYTE_CYC + CD);
    check("full_seen", {31'd0, full_cycles != base_full}, {31'd0, n >= DEPTH + 1});
    for (int i = 0; i < acc; i++)
      if (!wr_ign[i] && exp_rx.size() < DEPTH)
        exp_rx.push_back(miso_mode ? 8'hFF : (wr_data[i] ^ {8{miso_inv}}));
    if (drain) begin
      foreach (exp_rx[i]) begin
        check("rx_avail", {31'd0, spi_data_avail}, 32'd1);
        read_port(1'b0, v);
        check("rx_data", {24'd0, v}, {24'd0, exp_rx[i]});
      end
      check("rx_empty_avail", {31'd0, spi_data_avail}, 32'd0);
      check("rx_empty_dout", {24'd0, spi_dout}, 32'd0);
    end
  endtask

  logic [7:0] rv;
  int n, guard;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_busy", {31'd0, spi_busy}, 32'd0);
    check("rst_empty", {31'd0, spi_buffer_empty}, 32'd1);
    check("rst_full", {31'd0, spi_buffer_full}, 32'd0);
    check("rst_avail", {31'd0, spi_data_avail}, 32'd0);
    check("rst_dout", {24'd0, spi_dout}, 32'd0);

    // single byte, loopback
    wr_data[0] = 8'hA5; wr_ign[0] = 1'b0;
    run_burst(1, 1'b1, 1'b1);

    // ignore response with miso held high
    miso_mode = 1'b1;
    wr_data[0] = 8'h3C; wr_ign[0] = 1'b1;
    run_burst(1, 1'b0, 1'b1);
    miso_mode = 1'b0;

    // three back-to-back bytes
    for (int i = 0; i < 3; i++) begin wr_data[i] = 8'($urandom); wr_ign[i] = 1'b0; end
    run_burst(3, 1'b0, 1'b1);

    // TX overflow: ten writes into depth eight
    for (int i = 0; i < 10; i++) begin wr_data[i] = 8'($urandom); wr_ign[i] = 1'b0; end
    run_burst(10, 1'b0, 1'b1);

    // status read must not pop
    wr_data[0] = 8'h11; wr_data[1] = 8'hE7; wr_ign[0] = 1'b0; wr_ign[1] = 1'b0;
    run_burst(2, 1'b0, 1'b0);
    read_port(1'b1, rv);
    check("status_keeps_avail", {31'd0, spi_data_avail}, 32'd1);
    check("status_keeps_head", {24'd0, spi_dout}, 32'h11);
    read_port(1'b0, rv);
    check("data_read_0", {24'd0, rv}, 32'h11);
    check("avail_after_first", {31'd0, spi_data_avail}, 32'd1);
    read_port(1'b0, rv);
    check("data_read_1", {24'd0, rv}, 32'hE7);
    check("avail_after_second", {31'd0, spi_data_avail}, 32'd0);

    // randomized bursts with mixed ignore flags and miso inversion
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 10);
      miso_inv = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        wr_data[i] = 8'($urandom);
        wr_ign[i]  = ($urandom_range(0, 3) == 0);
      end
      run_burst(n, 1'b0, 1'b1);
    end
    miso_inv = 1'b0;

    // reset mid-byte with data in both FIFOs
    wr_data[0] = 8'h5A; wr_ign[0] = 1'b0;
    run_burst(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin wr_data[i] = 8'($urandom); wr_ign[i] = 1'b0; end
    n = rise_total;
    write_burst(3);
    guard = 0;
    while (rise_total - n < 4 && guard < 4 * BYTE_CYC) begin tick(); guard++; end
    check("reach_edge7_timeout", {31'd0, guard < 4 * BYTE_CYC}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    check("mid_rst_busy", {31'd0, spi_busy}, 32'd0);
    check("mid_rst_tx_empty", {31'd0, spi_buffer_empty}, 32'd1);
    check("mid_rst_rx_avail", {31'd0, spi_data_avail}, 32'd0);
    check("mid_rst_dout", {24'd0, spi_dout}, 32'd0);
    rst = 1'b0;
    tick();
    wr_data[0] = 8'h96; wr_ign[0] = 1'b0;
    run_burst(1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
